// File: rtl/selector_tablero.sv
// Board cell selector: an N x N cursor driven by direction buttons, plus a
// two-state commit FSM that writes the current player's mark into the board.
module selector_tablero #(
  parameter int N        = 3,
  parameter int ENVOLVER = 0,
  parameter int RECENTRA = 1,
  parameter int IW       = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boton_arriba,
  input  logic              boton_abajo,
  input  logic              boton_izq,
  input  logic              boton_der,
  input  logic              boton_elige,
  input  logic              borrar,
  input  logic              turno_p1,
  input  logic              turno_p2,
  output logic [IW-1:0]     cuadro,
  output logic [2*N*N-1:0]  tablero,
  output logic              p1_mm,
  output logic              p2_mm,
  output logic              rechazo,
  output logic              lleno
);

  localparam int            CW     = $clog2(N*N+1);
  localparam logic [IW-1:0] CENTRO = IW'((N*N)/2);
  localparam logic [IW-1:0] LADO   = IW'(N);
  localparam logic [IW-1:0] ULTIMO = IW'(N-1);
  localparam logic [IW-1:0] SALTO  = IW'((N-1)*N);
  localparam logic [IW-1:0] UNO    = IW'(1);
  localparam logic [CW-1:0] TOTAL  = CW'(N*N);

  typedef enum logic {NAVEGA = 1'b0, GUARDA = 1'b1} estado_t;

  estado_t             estado_q;
  logic [IW-1:0]       cuadro_q;
  logic [IW-1:0]       sel_q;
  logic [2*N*N-1:0]    tablero_q;
  logic [CW-1:0]       cuenta_q;
  logic                lleno_q;
  logic                p1_mm_q;
  logic                p2_mm_q;
  logic                rechazo_q;

  logic [IW-1:0]       fila_s;
  logic [IW-1:0]       col_s;
  logic [IW-1:0]       mov_d;
  logic                mueve_s;
  logic [1:0]          celda_s;
  logic [1:0]          marca_s;
  logic                turno_ok_s;
  logic                commit_s;

  assign fila_s = cuadro_q / LADO;
  assign col_s  = cuadro_q % LADO;

  // Next cursor position from the direction buttons, arriba first
  always_comb begin
    mov_d   = cuadro_q;
    mueve_s = 1'b1;
    if (boton_arriba) begin
      if (fila_s != '0)        mov_d = cuadro_q - LADO;
      else if (ENVOLVER != 0)  mov_d = cuadro_q + SALTO;
      else                     mov_d = cuadro_q;
    end else if (boton_abajo) begin
      if (fila_s != ULTIMO)    mov_d = cuadro_q + LADO;
      else if (ENVOLVER != 0)  mov_d = cuadro_q - SALTO;
      else                     mov_d = cuadro_q;
    end else if (boton_izq) begin
      if (col_s != '0)         mov_d = cuadro_q - UNO;
      else if (ENVOLVER != 0)  mov_d = cuadro_q + ULTIMO;
      else                     mov_d = cuadro_q;
    end else if (boton_der) begin
      if (col_s != ULTIMO)     mov_d = cuadro_q + UNO;
      else if (ENVOLVER != 0)  mov_d = cuadro_q - ULTIMO;
      else                     mov_d = cuadro_q;
    end else begin
      mueve_s = 1'b0;
    end
  end

  // Turno is judged in the GUARDA cycle itself, so a late player change still counts
  assign celda_s    = tablero_q[{sel_q, 1'b0} +: 2];
  assign turno_ok_s = turno_p1 ^ turno_p2;
  assign marca_s    = turno_p1 ? 2'b11 : 2'b01;
  assign commit_s   = (celda_s == 2'b00) && turno_ok_s && (cuenta_q != TOTAL);

  // Navigation/commit FSM with registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= NAVEGA;
      cuadro_q  <= CENTRO;
      sel_q     <= '0;
      tablero_q <= '0;
      cuenta_q  <= '0;
      lleno_q   <= 1'b0;
      p1_mm_q   <= 1'b0;
      p2_mm_q   <= 1'b0;
      rechazo_q <= 1'b0;
    end else if (borrar) begin
      estado_q  <= NAVEGA;
      cuadro_q  <= CENTRO;
      tablero_q <= '0;
      cuenta_q  <= '0;
      lleno_q   <= 1'b0;
      p1_mm_q   <= 1'b0;
      p2_mm_q   <= 1'b0;
      rechazo_q <= 1'b0;
    end else begin
      p1_mm_q   <= 1'b0;
      p2_mm_q   <= 1'b0;
      rechazo_q <= 1'b0;
      case (estado_q)
        NAVEGA: begin
          if (mueve_s) begin
            cuadro_q <= mov_d;
          end else if (boton_elige) begin
            sel_q    <= cuadro_q;
            estado_q <= GUARDA;
          end
        end
        GUARDA: begin
          estado_q <= NAVEGA;
          if (commit_s) begin
            tablero_q[{sel_q, 1'b0} +: 2] <= marca_s;
            cuenta_q <= cuenta_q + CW'(1);
            lleno_q  <= ((cuenta_q + CW'(1)) == TOTAL);
            if (turno_p1) p1_mm_q <= 1'b1;
            else          p2_mm_q <= 1'b1;
            if (RECENTRA != 0) cuadro_q <= CENTRO;
          end else begin
            rechazo_q <= 1'b1;
          end
        end
        default: estado_q <= NAVEGA;
      endcase
    end
  end

  assign cuadro  = cuadro_q;
  assign tablero = tablero_q;
  assign p1_mm   = p1_mm_q;
  assign p2_mm   = p2_mm_q;
  assign rechazo = rechazo_q;
  assign lleno   = lleno_q;

endmodule

// File: tb/tb_selector_tablero.sv
// Directed bench: saturating and wrapping 3x3 boards plus a 4x4 board share
// one stimulus stream; each phase checks only the instance it targets.
module tb_selector_tablero;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arr = 1'b0, aba = 1'b0, izq = 1'b0, der = 1'b0, eli = 1'b0, bor = 1'b0;
  logic t1 = 1'b0, t2 = 1'b0;

  logic [3:0]  cu_a, cu_w, cu_4;
  logic [17:0] tb_a, tb_w;
  logic [31:0] tb_4;
  logic p1_a, p2_a, re_a, ll_a;
  logic p1_w, p2_w, re_w, ll_w;
  logic p1_4, p2_4, re_4, ll_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  selector_tablero #(.N(3), .ENVOLVER(0), .RECENTRA(1)) dut (
    .clk(clk), .rst(rst), .boton_arriba(arr), .boton_abajo(aba), .boton_izq(izq),
    .boton_der(der), .boton_elige(eli), .borrar(bor), .turno_p1(t1), .turno_p2(t2),
    .cuadro(cu_a), .tablero(tb_a), .p1_mm(p1_a), .p2_mm(p2_a), .rechazo(re_a), .lleno(ll_a));

  selector_tablero #(.N(3), .ENVOLVER(1), .RECENTRA(1)) dut_w (
    .clk(clk), .rst(rst), .boton_arriba(arr), .boton_abajo(aba), .boton_izq(izq),
    .boton_der(der), .boton_elige(eli), .borrar(bor), .turno_p1(t1), .turno_p2(t2),
    .cuadro(cu_w), .tablero(tb_w), .p1_mm(p1_w), .p2_mm(p2_w), .rechazo(re_w), .lleno(ll_w));

  selector_tablero #(.N(4), .ENVOLVER(0), .RECENTRA(1)) dut4 (
    .clk(clk), .rst(rst), .boton_arriba(arr), .boton_abajo(aba), .boton_izq(izq),
    .boton_der(der), .boton_elige(eli), .borrar(bor), .turno_p1(t1), .turno_p2(t2),
    .cuadro(cu_4), .tablero(tb_4), .p1_mm(p1_4), .p2_mm(p2_4), .rechazo(re_4), .lleno(ll_4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state and the basic arriba/izq/elige commit
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_cuadro", cu_a, 4);
    chk("rst_tablero", tb_a, 0);
    chk("rst_pulsos", {p1_a, p2_a, re_a}, 3'b000);
    chk("rst_lleno", ll_a, 0);
    chk("rst_cuadro_n4", cu_4, 8);
    arr = 1'b1; tick(); arr = 1'b0;
    chk("arriba", cu_a, 1);
    izq = 1'b1; tick(); izq = 1'b0;
    chk("izq", cu_a, 0);
    t1 = 1'b1; t2 = 1'b0;
    eli = 1'b1; tick(); eli = 1'b0;
    chk("elige_cuadro", cu_a, 0);
    chk("elige_sin_pulso", {p1_a, p2_a, re_a}, 3'b000);
    tick();
    chk("commit_tablero", tb_a, 18'h3);
    chk("commit_p1", {p1_a, p2_a, re_a}, 3'b100);
    chk("commit_centro", cu_a, 4);
    tick();
    chk("p1_un_ciclo", {p1_a, p2_a, re_a}, 3'b000);

    // Edge behaviour: saturate vs wrap
    rst = 1'b1; tick(); rst = 1'b0;
    arr = 1'b1; tick(); arr = 1'b0;
    izq = 1'b1; tick(); izq = 1'b0;
    chk("w_en_0", cu_w, 0);
    izq = 1'b1; tick(); izq = 1'b0;
    chk("sat_izq", cu_a, 0);
    chk("wrap_izq", cu_w, 2);
    der = 1'b1; tick(); der = 1'b0;
    chk("wrap_der", cu_w, 0);
    chk("sat_der_mov", cu_a, 1);
    arr = 1'b1; tick(); arr = 1'b0;
    chk("sat_arriba", cu_a, 1);
    chk("wrap_arriba", cu_w, 6);
    aba = 1'b1; tick(); aba = 1'b0;
    chk("wrap_abajo", cu_w, 0);
    chk("abajo", cu_a, 4);

    // Occupied cell and invalid turno rejection
    rst = 1'b1; tick(); rst = 1'b0;
    t1 = 1'b1; t2 = 1'b0;
    eli = 1'b1; tick(); eli = 1'b0; tick();
    chk("commit4_tablero", tb_a, 18'h300);
    t1 = 1'b0; t2 = 1'b1;
    eli = 1'b1; tick(); eli = 1'b0; tick();
    chk("ocupada_rechazo", {p1_a, p2_a, re_a}, 3'b001);
    chk("ocupada_tablero", tb_a, 18'h300);
    chk("ocupada_cuadro", cu_a, 4);
    tick();
    chk("rechazo_un_ciclo", {p1_a, p2_a, re_a}, 3'b000);
    t1 = 1'b1; t2 = 1'b1;
    der = 1'b1; tick(); der = 1'b0;
    eli = 1'b1; tick(); eli = 1'b0; tick();
    chk("turno_doble_rechazo", {p1_a, p2_a, re_a}, 3'b001);
    chk("turno_doble_tablero", tb_a, 18'h300);
    chk("turno_doble_cuadro", cu_a, 5);
    arr = 1'b1; eli = 1'b1; tick(); arr = 1'b0; eli = 1'b0;
    chk("prioridad_mueve", cu_a, 2);
    tick();
    chk("prioridad_sin_guarda", {p1_a, p2_a, re_a}, 3'b000);

    // Turno is sampled in GUARDA, not at elige
    t1 = 1'b0; t2 = 1'b0;
    eli = 1'b1; tick(); eli = 1'b0;
    t2 = 1'b1; tick();
    chk("turno_tardio_p2", {p1_a, p2_a, re_a}, 3'b010);
    chk("turno_tardio_tablero", tb_a, 18'h310);
    chk("turno_tardio_cuadro", cu_a, 4);

    // borrar in GUARDA drops the commit and overrides a move
    arr = 1'b1; tick(); arr = 1'b0;
    izq = 1'b1; tick(); izq = 1'b0;
    t1 = 1'b1; t2 = 1'b0;
    eli = 1'b1; tick(); eli = 1'b0;
    bor = 1'b1; arr = 1'b1; tick(); bor = 1'b0; arr = 1'b0;
    chk("borrar_tablero", tb_a, 0);
    chk("borrar_pulsos", {p1_a, p2_a, re_a}, 3'b000);
    chk("borrar_cuadro", cu_a, 4);
    tick();
    chk("borrar_sin_commit", {p1_a, p2_a, re_a, tb_a}, 21'h0);

    // rst in GUARDA aborts the commit
    eli = 1'b1; tick(); eli = 1'b0; tick();
    chk("pre_rst_tablero", tb_a, 18'h300);
    der = 1'b1; tick(); der = 1'b0;
    eli = 1'b1; tick(); eli = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_guarda_tablero", tb_a, 0);
    chk("rst_guarda_pulsos", {p1_a, p2_a, re_a, ll_a}, 4'b0000);
    chk("rst_guarda_cuadro", cu_a, 4);
    tick();
    chk("rst_guarda_sin_pulso", {p1_a, p2_a, re_a, tb_a}, 21'h0);

    // 4x4 board: fill every cell alternating players
    rst = 1'b1; tick(); rst = 1'b0;
    chk("n4_rst", {cu_4, tb_4}, {4'd8, 32'h0});
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 2 - k / 4; i++) begin arr = 1'b1; tick(); arr = 1'b0; end
      for (int i = 0; i < k / 4 - 2; i++) begin aba = 1'b1; tick(); aba = 1'b0; end
      for (int i = 0; i < k % 4; i++) begin der = 1'b1; tick(); der = 1'b0; end
      chk("n4_cursor", cu_4, k);
      t1 = (k % 2 == 0); t2 = !t1;
      eli = 1'b1; tick(); eli = 1'b0; tick();
      chk("n4_pulso", {p1_4, p2_4, re_4}, t1 ? 3'b100 : 3'b010);
      chk("n4_lleno", ll_4, (k == 15));
      chk("n4_centro", cu_4, 8);
    end
    chk("n4_tablero_lleno", tb_4, 32'h77777777);
    t1 = 1'b1; t2 = 1'b0;
    eli = 1'b1; tick(); eli = 1'b0; tick();
    chk("n4_lleno_rechazo", {p1_4, p2_4, re_4}, 3'b001);
    chk("n4_lleno_tablero", tb_4, 32'h77777777);
    chk("n4_lleno_sigue", ll_4, 1);
    bor = 1'b1; tick(); bor = 1'b0;
    chk("n4_borrar_tablero", tb_4, 0);
    chk("n4_borrar_lleno", ll_4, 0);
    chk("n4_borrar_cuadro", cu_4, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/selector_tablero.md
SELECTOR_TABLERO -- requirements
Module: selector_tablero

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning board side length; legal range 2..8.
REQ-002 The block SHALL have parameter ENVOLVER, default 0, meaning 0 = cursor saturates at board edges, 1 = cursor wraps within its row/column.
REQ-003 The block SHALL have parameter RECENTRA, default 1, meaning 1 = cursor returns to centre after a commit, 0 = cursor stays on the committed cell.
REQ-004 The block SHALL have parameter IW, default $clog2(N*N), meaning cursor index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have ports boton_arriba, boton_abajo, boton_izq, boton_der, each input, 1 bit: one-cycle move requests.
REQ-008 The block SHALL have port boton_elige, input, 1 bit: one-cycle select request.
REQ-009 The block SHALL have port borrar, input, 1 bit: clear board and restart selection.
REQ-010 The block SHALL have ports turno_p1 and turno_p2, each input, 1 bit: current player; valid only when exactly one is high.
REQ-011 The block SHALL have port cuadro, output, IW bits: cursor index, row-major, 0..N*N-1.
REQ-012 The block SHALL have port tablero, output, 2*N*N bits: cell k occupies bits [2k+1:2k]; 00 = empty, 11 = player 1, 01 = player 2.
REQ-013 The block SHALL have ports p1_mm and p2_mm, each output, 1 bit: one-cycle pulse when that player's mark is committed.
REQ-014 The block SHALL have port rechazo, output, 1 bit: one-cycle pulse when a select is refused.
REQ-015 The block SHALL have port lleno, output, 1 bit: high while all N*N cells are occupied.

Function
REQ-016 The FSM SHALL have exactly two states: NAVEGA and GUARDA.
REQ-017 In NAVEGA, inputs SHALL be evaluated with priority arriba > abajo > izq > der > elige; at most one action is taken per cycle.
REQ-018 Moves SHALL use row r = cuadro / N and column c = cuadro % N: arriba r-1, abajo r+1, izq c-1, der c+1.
REQ-019 At an edge with ENVOLVER=0, the cursor SHALL hold; with ENVOLVER=1, it SHALL wrap to the opposite end of the same row or column.
REQ-020 A move SHALL update cuadro on the next clock edge (latency 1).
REQ-021 When elige is accepted in NAVEGA, the block SHALL latch the target index (sel_idx) and enter GUARDA on the next edge; cuadro is unchanged.
REQ-022 In GUARDA, all buttons SHALL be ignored and the block SHALL return to NAVEGA unconditionally after one cycle.
REQ-023 GUARDA commit, when the cell is empty and exactly one turno is high: write 11 (turno_p1) or 01 (turno_p2) to cell sel_idx; pulse p1_mm or p2_mm for one cycle; increment the occupied counter.
REQ-024 GUARDA reject, when the cell is occupied or the turno inputs are invalid: leave tablero unchanged; pulse rechazo for one cycle; no p1_mm/p2_mm pulse.
REQ-025 The turno inputs SHALL be sampled during the GUARDA cycle, not at elige.
REQ-026 On commit with RECENTRA=1, cuadro SHALL be set to (N*N)/2; on reject, or with RECENTRA=0, cuadro SHALL be unchanged.
REQ-027 The p1_mm, p2_mm and rechazo outputs SHALL be registered, mutually exclusive, and asserted for the cycle after the GUARDA edge.
REQ-028 The occupied counter SHALL be $clog2(N*N+1) bits wide and SHALL never exceed N*N; lleno = (counter == N*N).
REQ-029 When lleno=1, every elige SHALL result in rechazo.
REQ-030 When borrar is high at any edge, in any state, the block SHALL clear tablero and the counter, set cuadro to (N*N)/2, enter NAVEGA, and drop any pending commit.
REQ-031 borrar SHALL override all buttons in the same cycle; rst SHALL override borrar.

Reset
REQ-032 When rst is high at a rising edge, the block SHALL set state = NAVEGA, cuadro = (N*N)/2 (4 for N=3), tablero = 0, counter = 0, p1_mm = p2_mm = rechazo = 0, lleno = 0.
REQ-033 Reset asserted during GUARDA SHALL abort the commit: no tablero write and no pulse.

Verification
REQ-034 N=3, reset, then arriba, izq, elige with turno_p1=1 -> cuadro 1 then 0, tablero[1:0]=11, p1_mm pulses 1 cycle, cuadro returns to 4.
REQ-035 N=3, ENVOLVER=0, cursor at 0, pulse arriba and izq -> cuadro stays 0; with ENVOLVER=1, izq from 0 -> 2 and arriba from 0 -> 6.
REQ-036 Commit p1 on cell 4, then elige on cell 4 with turno_p2=1 -> rechazo pulses, tablero[9:8] stays 11, p2_mm stays 0.
REQ-037 turno_p1=turno_p2=1 at GUARDA -> rechazo pulses, tablero unchanged; arriba and elige asserted in the same cycle -> move only, no GUARDA.
REQ-038 N=4, fill all 16 cells alternating players -> lleno=1 after the 16th commit, the 17th elige is rejected; then borrar -> tablero=0, lleno=0, cuadro=8.
REQ-039 Assert rst in the GUARDA cycle -> no write, no pulse, all outputs at reset values next cycle.
